tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of byte-stream requesters (2..4).
REQ-002 Parameter TIMEOUT, default 1024, idle cycles before a stalled owner is dropped (>=2).
REQ-003 i_clk  input  1  single clock, all logic on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_req_data  input  8*NREQ  byte from requester k in bits [8k+7:8k].
REQ-006 i_req_stb  input  NREQ  requester k has a byte; held with data until acked.
REQ-007 i_req_last  input  NREQ  byte presented by k ends its packet.
REQ-008 o_req_ack  output  NREQ  one-cycle pulse: byte of k captured.
REQ-009 o_tx_data  output  8  byte to UART transmitter.
REQ-010 o_tx_stb  output  1  o_tx_data valid; held until accepted.
REQ-011 i_tx_busy  input  1  transmitter cannot accept.
REQ-012 o_owner  output  2  index of current/last grant holder.
REQ-013 o_busy  output  1  high whenever state is not IDLE.
REQ-014 o_timeout  output  1  one-cycle pulse when an owner is dropped by timeout.

Function
REQ-015 TX handshake: byte accepted in cycle where o_tx_stb=1 and i_tx_busy=0; o_tx_data/o_tx_stb stable until then.
REQ-016 States: IDLE (no owner), GRANT (owner holds bus, waiting for its byte), SEND (byte held on o_tx_*).
REQ-017 IDLE: if any i_req_stb high, pick winner round-robin, search starting at (o_owner+1) mod NREQ; capture its byte, pulse its ack same cycle, set o_owner, go SEND.
REQ-018 Latency: capture in cycle t -> o_tx_stb=1 in cycle t+1.
REQ-019 GRANT: only owner's i_req_stb considered; other requesters never acked; owner byte captured and acked same cycle, go SEND.
REQ-020 SEND: on TX acceptance, drop o_tx_stb; if captured byte had last=1 go IDLE, else go GRANT.
REQ-021 No byte capture while in SEND (at most one byte buffered).
REQ-022 Timeout counter clears on entry to GRANT and on every owner byte; increments each GRANT cycle without owner stb; at TIMEOUT-1 go IDLE and pulse o_timeout.
REQ-023 Owner asserting stb in the timeout cycle: capture wins, no timeout.
REQ-024 Simultaneous requests in IDLE: exactly one ack per cycle; losers keep stb and wait.
REQ-025 Single requester: re-granted each packet without gap beyond IDLE cycle.
REQ-026 i_req_last ignored when i_req_stb low; last flag latched with the byte.

Reset
REQ-027 Reset asynchronously forces IDLE, o_tx_stb=0, o_tx_data=0, o_req_ack=0, o_owner=NREQ-1, o_busy=0, o_timeout=0, counter=0.
REQ-028 Reset mid-SEND discards the held byte; no acceptance counted.
REQ-029 First grant after reset searches from requester 0.

Structure
REQ-030 State enum and default TIMEOUT/NREQ constants live in shared package ihex_pkg.
REQ-031 Round-robin selection in sub-module rr_pick (inputs request vector, last index; outputs valid, index), purely combinational.
REQ-032 Counter width $clog2(TIMEOUT); no other arithmetic.

Verification
REQ-033 Req0 sends 0x3A,0x30(last) with busy=0 -> o_tx_data 0x3A then 0x30, each 1 cycle after ack, owner=0, back to IDLE.
REQ-034 Req0 and req1 both stb in IDLE after reset -> req0 granted; next packet req1 granted while req0 keeps requesting.
REQ-035 Req1 stb mid req0 packet -> req1 no ack until req0 last byte accepted.
REQ-036 i_tx_busy high 5 cycles during SEND -> o_tx_data/o_tx_stb unchanged 5 cycles, no new ack.
REQ-037 TIMEOUT=4, owner stops after non-last byte -> o_timeout pulses 4 cycles after GRANT entry, other requester then granted.
REQ-038 Reset asserted in SEND -> o_tx_stb low immediately, o_busy=0, no ack pulses.

Source files
------------

// File: rtl/ihex_pkg.sv
// ----------------------------------------------------------------------------
// ihex_pkg
// Shared definitions for the transmit arbiter: FSM state encoding, default
// requester count / stall timeout, and the width of the owner index.
// No ports (package).
// ----------------------------------------------------------------------------
package ihex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no owner, looking for a new packet
        ST_GRANT = 2'd1,   // owner holds the bus, waiting for its next byte
        ST_SEND  = 2'd2    // one byte buffered on the transmitter interface
    } arb_state_t;

    localparam int DEFAULT_NREQ    = 2;
    localparam int DEFAULT_TIMEOUT = 1024;

    // Owner index is always 2 bits wide so up to four requesters fit.
    localparam int OWNER_W = 2;

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin selector. Returns the first requester
// after i_last (wrapping around), so the previous winner has lowest priority.
//
// Ports
//   i_req    [NREQ-1:0]    request vector
//   i_last   [OWNER_W-1:0] index of the previous winner
//   o_valid                at least one request is present
//   o_index  [OWNER_W-1:0] chosen requester (meaningful when o_valid)
// ----------------------------------------------------------------------------
module rr_pick
    import ihex_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ
) (
    input  logic [NREQ-1:0]    i_req,
    input  logic [OWNER_W-1:0] i_last,
    output logic               o_valid,
    output logic [OWNER_W-1:0] o_index
);

    logic               hi_valid;
    logic [OWNER_W-1:0] hi_index;
    logic               any_valid;
    logic [OWNER_W-1:0] any_index;

    // Two priority searches instead of a modulo add: the lowest requester
    // above i_last wins; if there is none, the search wraps to the lowest
    // requester overall. Scanning downward lets lower indices overwrite.
    // NOTE: every output of a combinational block gets a default before any
    // condition, otherwise the missing paths would infer latches.
    always_comb begin
        hi_valid  = 1'b0;
        hi_index  = '0;
        any_valid = 1'b0;
        any_index = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                any_valid = 1'b1;
                any_index = OWNER_W'(k);
                if (k > int'(i_last)) begin
                    hi_valid = 1'b1;
                    hi_index = OWNER_W'(k);
                end
            end
        end
    end

    assign o_valid = any_valid;
    assign o_index = hi_valid ? hi_index : any_index;

endmodule

// File: rtl/tx_arbiter.sv
// ----------------------------------------------------------------------------
// tx_arbiter
// Shares one byte-wide UART transmitter between NREQ packet streams. A
// requester that wins arbitration keeps the transmitter for its whole packet
// (until a byte flagged last is sent) unless it stalls for TIMEOUT cycles.
// One byte is buffered at a time.
//
// Ports
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_req_data [8*NREQ-1:0]   byte from requester k in bits [8k+7:8k]
//   i_req_stb  [NREQ-1:0]     requester k presents a byte (held until acked)
//   i_req_last [NREQ-1:0]     presented byte ends requester k's packet
//   o_req_ack  [NREQ-1:0]     one-cycle pulse: byte of requester k captured
//   o_tx_data  [7:0]          byte to the transmitter
//   o_tx_stb                  o_tx_data valid, held until accepted
//   i_tx_busy                 transmitter cannot accept this cycle
//   o_owner    [1:0]          current / most recent grant holder
//   o_busy                    arbiter not idle
//   o_timeout                 one-cycle pulse: stalled owner was dropped
// ----------------------------------------------------------------------------
module tx_arbiter
    import ihex_pkg::*;
#(
    parameter int NREQ    = DEFAULT_NREQ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [8*NREQ-1:0]   i_req_data,
    input  logic [NREQ-1:0]     i_req_stb,
    input  logic [NREQ-1:0]     i_req_last,
    output logic [NREQ-1:0]     o_req_ack,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_stb,
    input  logic                i_tx_busy,
    output logic [OWNER_W-1:0]  o_owner,
    output logic                o_busy,
    output logic                o_timeout
);

    localparam int                 CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMEOUT - 1);
    // Owner resets to the highest index so the first search starts at 0.
    localparam logic [OWNER_W-1:0] OWNER_RST = OWNER_W'(NREQ - 1);

    arb_state_t         state_q, state_d;
    logic [7:0]         data_q, data_d;
    logic               last_q, last_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic               tx_stb_q, tx_stb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic               pick_valid;
    logic [OWNER_W-1:0] pick_idx;
    logic               owner_stb;
    logic               tx_accept;
    logic               cnt_expired;
    logic               capture;
    logic [OWNER_W-1:0] cap_idx;
    logic [7:0]         cap_data;
    logic               cap_last;
    logic               timeout_fire;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req   (i_req_stb),
        .i_last  (owner_q),
        .o_valid (pick_valid),
        .o_index (pick_idx)
    );

    always_comb begin
        owner_stb = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (owner_q == OWNER_W'(k)) begin
                owner_stb = i_req_stb[k];
            end
        end
    end

    assign tx_accept   = tx_stb_q & ~i_tx_busy;
    assign cnt_expired = (cnt_q == CNT_LAST);

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_SEND;
                end
            end
            ST_GRANT: begin
                // A byte arriving in the expiry cycle beats the timeout.
                if (owner_stb) begin
                    state_d = ST_SEND;
                end else if (cnt_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tx_accept) begin
                    state_d = last_q ? ST_IDLE : ST_GRANT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- output / capture decode ----------------
    always_comb begin
        capture      = 1'b0;
        cap_idx      = owner_q;
        timeout_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                capture = pick_valid;
                cap_idx = pick_idx;
            end
            ST_GRANT: begin
                capture      = owner_stb;
                timeout_fire = ~owner_stb & cnt_expired;
            end
            default: ;
        endcase

        cap_data  = 8'h00;
        cap_last  = 1'b0;
        o_req_ack = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (cap_idx == OWNER_W'(k)) begin
                cap_data = i_req_data[8*k +: 8];
                cap_last = i_req_last[k];
                // Ack is combinational; mask it while reset is held so a
                // requester is never told a discarded byte was taken.
                o_req_ack[k] = capture & ~i_reset;
            end
        end
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        data_d    = capture ? cap_data : data_q;
        last_d    = capture ? cap_last : last_q;
        owner_d   = capture ? cap_idx  : owner_q;
        // Capture only happens with nothing buffered, so set and clear
        // never coincide.
        tx_stb_d  = capture | (tx_stb_q & ~tx_accept);
        // Counter is zero everywhere except while an owner stalls in GRANT,
        // which covers clearing on GRANT entry and on every owner byte.
        cnt_d     = '0;
        if (state_q == ST_GRANT && !owner_stb && !cnt_expired) begin
            cnt_d = cnt_q + 1'b1;
        end
        timeout_d = timeout_fire;
    end

    // NOTE: the byte buffer is a plain register, not a memory, so it is given
    // a reset value like any other flop and reads as zero after reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            data_q    <= 8'h00;
            last_q    <= 1'b0;
            owner_q   <= OWNER_RST;
            tx_stb_q  <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            tx_stb_q  <= tx_stb_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_tx_data = data_q;
    assign o_tx_stb  = tx_stb_q;
    assign o_owner   = owner_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tx_arbiter
// Drives tx_arbiter (NREQ=3, TIMEOUT=4) with a table of arbitration
// vectors, directed multi-cycle sequences and randomized packet traffic.
// A transaction-level model of the arbitration rules runs alongside and
// compares every output on each falling clock edge.
// ----------------------------------------------------------------------------
module tb_tx_arbiter;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 4;

    logic                i_clk = 1'b0;
    logic                i_reset;
    logic [8*NREQ-1:0]   i_req_data;
    logic [NREQ-1:0]     i_req_stb;
    logic [NREQ-1:0]     i_req_last;
    logic [NREQ-1:0]     o_req_ack;
    logic [7:0]          o_tx_data;
    logic                o_tx_stb;
    logic                i_tx_busy;
    logic [1:0]          o_owner;
    logic                o_busy;
    logic                o_timeout;

    tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_req_data (i_req_data),
        .i_req_stb  (i_req_stb),
        .i_req_last (i_req_last),
        .o_req_ack  (o_req_ack),
        .o_tx_data  (o_tx_data),
        .o_tx_stb   (o_tx_stb),
        .i_tx_busy  (i_tx_busy),
        .o_owner    (o_owner),
        .o_busy     (o_busy),
        .o_timeout  (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: owner, one-byte buffer, "mid packet" flag and a
    // stall count. Outputs for the current cycle are derived from these
    // plus the sampled inputs; the state advances once per cycle.
    // ------------------------------------------------------------------
    int              m_owner;
    bit              m_hold;
    logic [7:0]      m_data;
    bit              m_last;
    bit              m_pkt;
    int              m_idle;
    bit              m_to;

    always @(negedge i_clk) begin
        int              win;
        int              k;
        logic [NREQ-1:0] eack;
        if (i_reset) begin
            check("rst_ack",     o_req_ack, '0);
            check("rst_tx_stb",  o_tx_stb,  0);
            check("rst_tx_data", o_tx_data, 0);
            check("rst_owner",   o_owner,   NREQ - 1);
            check("rst_busy",    o_busy,    0);
            check("rst_timeout", o_timeout, 0);
            m_owner <= NREQ - 1;
            m_hold  <= 1'b0;
            m_data  <= 8'h00;
            m_last  <= 1'b0;
            m_pkt   <= 1'b0;
            m_idle  <= 0;
            m_to    <= 1'b0;
        end else begin
            win = -1;
            if (!m_hold) begin
                if (!m_pkt) begin
                    for (int off = 1; off <= NREQ; off++) begin
                        k = (m_owner + off) % NREQ;
                        if (win < 0 && i_req_stb[k]) win = k;
                    end
                end else if (i_req_stb[m_owner]) begin
                    win = m_owner;
                end
            end
            eack = '0;
            if (win >= 0) eack[win] = 1'b1;

            check("m_ack",     o_req_ack, eack);
            check("m_tx_stb",  o_tx_stb,  m_hold);
            if (m_hold) check("m_tx_data", o_tx_data, m_data);
            check("m_owner",   o_owner,   m_owner);
            check("m_busy",    o_busy,    m_hold || m_pkt);
            check("m_timeout", o_timeout, m_to);

            m_to <= 1'b0;
            if (m_hold) begin
                if (!i_tx_busy) begin
                    m_hold <= 1'b0;
                    m_pkt  <= !m_last;
                    m_idle <= 0;
                end
            end else if (win >= 0) begin
                m_hold  <= 1'b1;
                m_data  <= i_req_data[8*win +: 8];
                m_last  <= i_req_last[win];
                m_owner <= win;
                m_pkt   <= 1'b0;
                m_idle  <= 0;
            end else if (m_pkt) begin
                if (m_idle == TIMEOUT - 1) begin
                    m_pkt  <= 1'b0;
                    m_to   <= 1'b1;
                    m_idle <= 0;
                end else begin
                    m_idle <= m_idle + 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after a rising edge,
    // explicit checks happen on the falling edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic neg();
        @(negedge i_clk);
    endtask

    task automatic set_req(input int k, input bit stb, input logic [7:0] d, input bit last);
        i_req_stb[k]         = stb;
        i_req_data[8*k +: 8] = d;
        i_req_last[k]        = last;
    endtask

    task automatic clear_inputs();
        i_req_stb  = '0;
        i_req_last = '0;
        i_req_data = '0;
        i_tx_busy  = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        i_reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    typedef struct {
        int              prime;     // requester that sends one packet first, -1 none
        logic [NREQ-1:0] stb;
        logic [NREQ-1:0] exp_ack;
        logic [1:0]      exp_owner;
    } vec_t;

    vec_t vecs[14];
    int   left[NREQ];
    int   gap[NREQ];

    task automatic run_random(input int ncyc);
        logic [NREQ-1:0] ackv;
        do_reset();
        for (int k = 0; k < NREQ; k++) begin
            left[k] = $urandom_range(1, 4);
            gap[k]  = $urandom_range(0, 3);
        end
        for (int c = 0; c < ncyc; c++) begin
            neg();
            ackv = o_req_ack;
            tick();
            i_tx_busy = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < NREQ; k++) begin
                if (i_req_stb[k] && ackv[k]) begin
                    i_req_stb[k]  = 1'b0;
                    i_req_last[k] = 1'($urandom);   // must be ignored
                    left[k]--;
                    if (left[k] == 0) begin
                        left[k] = $urandom_range(1, 4);
                        gap[k]  = $urandom_range(0, 3);
                    end else begin
                        gap[k] = ($urandom_range(0, 4) == 0) ? $urandom_range(3, 6) : 0;
                    end
                end
                if (!i_req_stb[k]) begin
                    if (gap[k] > 0) gap[k]--;
                    else set_req(k, 1'b1, 8'($urandom), left[k] == 1);
                end
            end
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        clear_inputs();

        // Reset state
        neg();
        check("reset_owner",   o_owner,   2);
        check("reset_busy",    o_busy,    0);
        check("reset_tx_stb",  o_tx_stb,  0);
        check("reset_tx_data", o_tx_data, 0);
        check("reset_ack",     o_req_ack, 0);
        tick();
        i_reset = 1'b0;

        // ---------------- round-robin table ----------------
        vecs[0]  = '{-1, 3'b001, 3'b001, 2'd0};
        vecs[1]  = '{-1, 3'b010, 3'b010, 2'd1};
        vecs[2]  = '{-1, 3'b100, 3'b100, 2'd2};
        vecs[3]  = '{-1, 3'b110, 3'b010, 2'd1};
        vecs[4]  = '{-1, 3'b111, 3'b001, 2'd0};
        vecs[5]  = '{-1, 3'b000, 3'b000, 2'd2};
        vecs[6]  = '{-1, 3'b101, 3'b001, 2'd0};
        vecs[7]  = '{ 0, 3'b101, 3'b100, 2'd2};
        vecs[8]  = '{ 0, 3'b011, 3'b010, 2'd1};
        vecs[9]  = '{ 0, 3'b001, 3'b001, 2'd0};
        vecs[10] = '{ 1, 3'b101, 3'b100, 2'd2};
        vecs[11] = '{ 1, 3'b011, 3'b001, 2'd0};
        vecs[12] = '{ 2, 3'b110, 3'b010, 2'd1};
        vecs[13] = '{ 2, 3'b111, 3'b001, 2'd0};

        foreach (vecs[i]) begin
            do_reset();
            if (vecs[i].prime >= 0) begin
                set_req(vecs[i].prime, 1'b1, 8'hE0, 1'b1);
                neg();
                check("tbl_prime_ack", o_req_ack, 32'd1 << vecs[i].prime);
                tick();
                set_req(vecs[i].prime, 1'b0, 8'h00, 1'b0);
                neg();
                tick();
            end
            i_req_stb  = vecs[i].stb;
            i_req_last = '1;
            i_req_data = 24'hC2C1C0;
            neg();
            check("tbl_ack", o_req_ack, vecs[i].exp_ack);
            tick();
            i_req_stb = '0;
            neg();
            check("tbl_owner", o_owner, vecs[i].exp_owner);
            if (vecs[i].exp_ack != 0)
                check("tbl_data", o_tx_data, 8'hC0 + 8'(vecs[i].exp_owner));
        end

        // ---------------- two-byte packet from req0 ----------------
        do_reset();
        set_req(0, 1'b1, 8'h3A, 1'b0);
        neg();  check("p33_ack_first", o_req_ack, 3'b001);
        tick(); set_req(0, 1'b1, 8'h30, 1'b1);
        neg();  check("p33_stb_first", o_tx_stb, 1);
                check("p33_data_first", o_tx_data, 8'h3A);
                check("p33_no_ack_send", o_req_ack, 0);
                check("p33_owner", o_owner, 0);
        tick();
        neg();  check("p33_ack_last", o_req_ack, 3'b001);
                check("p33_stb_gap", o_tx_stb, 0);
        tick(); set_req(0, 1'b0, 8'h00, 1'b0);
        neg();  check("p33_data_last", o_tx_data, 8'h30);
                check("p33_stb_last", o_tx_stb, 1);
        tick();
        neg();  check("p33_idle", o_busy, 0);

        // ---------------- simultaneous requests ----------------
        do_reset();
        set_req(0, 1'b1, 8'hA0, 1'b1);
        set_req(1, 1'b1, 8'hA1, 1'b1);
        neg();  check("p34_req0_first", o_req_ack, 3'b001);
        tick(); set_req(0, 1'b1, 8'hB0, 1'b1);
        neg();  check("p34_send_no_ack", o_req_ack, 0);
        tick();
        neg();  check("p34_req1_next", o_req_ack, 3'b010);
        tick(); set_req(1, 1'b0, 8'h00, 1'b0);
        neg();  check("p34_data_req1", o_tx_data, 8'hA1);
        tick();
        neg();  check("p34_req0_again", o_req_ack, 3'b001);
        tick(); clear_inputs();

        // ---------------- intruder mid packet ----------------
        do_reset();
        set_req(0, 1'b1, 8'h11, 1'b0);
        neg();  check("p35_ack0", o_req_ack, 3'b001);
        tick(); set_req(0, 1'b0, 8'h00, 1'b0); set_req(1, 1'b1, 8'h21, 1'b1);
        for (int c = 0; c < 3; c++) begin
            neg(); check("p35_intruder_wait", o_req_ack, 0);
            tick();
        end
        set_req(0, 1'b1, 8'h12, 1'b1);
        neg();  check("p35_owner_byte", o_req_ack, 3'b001);
        tick(); set_req(0, 1'b0, 8'h00, 1'b0);
        neg();  check("p35_send_no_ack", o_req_ack, 0);
                check("p35_data", o_tx_data, 8'h12);
        tick();
        neg();  check("p35_intruder_granted", o_req_ack, 3'b010);
        tick(); clear_inputs();

        // ---------------- transmitter busy ----------------
        do_reset();
        i_tx_busy = 1'b1;
        set_req(0, 1'b1, 8'h55, 1'b1);
        neg();  check("p36_ack", o_req_ack, 3'b001);
        tick(); set_req(0, 1'b0, 8'h00, 1'b0); set_req(1, 1'b1, 8'h66, 1'b1);
        for (int c = 0; c < 5; c++) begin
            neg();
            check("p36_hold_stb",  o_tx_stb,  1);
            check("p36_hold_data", o_tx_data, 8'h55);
            check("p36_hold_noack", o_req_ack, 0);
            tick();
        end
        i_tx_busy = 1'b0;
        neg();  check("p36_accept_noack", o_req_ack, 0);
        tick();
        neg();  check("p36_next_grant", o_req_ack, 3'b010);
        tick(); clear_inputs();

        // ---------------- stalled owner times out ----------------
        do_reset();
        set_req(0, 1'b1, 8'h01, 1'b0);
        neg();  check("p37_ack", o_req_ack, 3'b001);
        tick(); set_req(0, 1'b0, 8'h00, 1'b0); set_req(1, 1'b1, 8'h77, 1'b1);
        neg();  tick();
        for (int g = 0; g < TIMEOUT; g++) begin
            neg();
            check("p37_no_timeout_yet", o_timeout, 0);
            check("p37_busy", o_busy, 1);
            tick();
        end
        neg();  check("p37_timeout", o_timeout, 1);
                check("p37_idle", o_busy, 0);
                check("p37_other_granted", o_req_ack, 3'b010);
        tick(); clear_inputs();

        // ---------------- owner byte in the expiry cycle ----------------
        do_reset();
        set_req(0, 1'b1, 8'h01, 1'b0);
        neg();  tick();
        set_req(0, 1'b0, 8'h00, 1'b0); set_req(1, 1'b1, 8'h77, 1'b1);
        neg();  tick();
        for (int g = 0; g < TIMEOUT - 1; g++) begin
            neg(); tick();
        end
        set_req(0, 1'b1, 8'h02, 1'b1);
        neg();  check("p23_late_ack", o_req_ack, 3'b001);
        tick(); set_req(0, 1'b0, 8'h00, 1'b0);
        neg();  check("p23_no_timeout", o_timeout, 0);
                check("p23_data", o_tx_data, 8'h02);
        tick(); clear_inputs();

        // ---------------- reset during SEND ----------------
        do_reset();
        i_tx_busy = 1'b1;
        set_req(0, 1'b1, 8'h77, 1'b1);
        neg();  tick();
        set_req(0, 1'b1, 8'h78, 1'b1);
        neg();  check("p38_sending", o_tx_stb, 1);
        #2 i_reset = 1'b1;
        #1;
        check("p38_stb_low", o_tx_stb, 0);
        check("p38_busy_low", o_busy, 0);
        check("p38_no_ack", o_req_ack, 0);
        tick();
        neg();
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        i_tx_busy = 1'b0;
        i_reset   = 1'b0;
        neg();  check("p38_discarded", o_tx_stb, 0);
        tick();

        // ---------------- randomized traffic ----------------
        run_random(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
